// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - round-robin 1-to-8 demux dispatch controller with stall timeout
//
// Optional statistics counters are enabled by defining DEMUX_DISPATCH_STATS_EN.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   en_mask[7:0]      per-channel enable for arbitration
//   in_valid/in_data  upstream word; in_ready is high only when idle with a nonzero mask
//   ch_valid[7:0]     one-hot offer to the granted channel (bit sel only)
//   ch_data[DW-1:0]   held word presented to all channels
//   ch_ready[7:0]     per-channel accept; only bit sel is looked at
//   sel[2:0]          granted channel (demux select)
//   busy              high while arbitrating or sending
//   xfer_cnt/skip_cnt saturating completed-transfer / timeout-skip counts (stats build only)

module demux_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    en_mask,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [7:0]    ch_valid,
  output logic [DW-1:0] ch_data,
  input  logic [7:0]    ch_ready,
  output logic [2:0]    sel,
  output logic          busy
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [15:0]   xfer_cnt,
  output logic [15:0]   skip_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // A timeout of 0 still needs a 1-bit timer so the logic elaborates.
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic [2:0]    ptr;
  logic [TW-1:0] timer;
  logic [DW-1:0] hold;

  logic          arb_found;
  logic [2:0]    arb_idx;
  logic [2:0]    scan_idx;
  logic          xfer_evt;
  logic          skip_evt;

  assign in_ready = !rst && (state == S_IDLE) && (|en_mask);

  // Scan from ptr upward with wrap; iterating from the far end down lets the
  // nearest enabled channel be the last (winning) assignment.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    scan_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      scan_idx = ptr + 3'(i);
      if (en_mask[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  assign xfer_evt = (state == S_SEND) && ch_ready[sel];
  assign skip_evt = (state == S_SEND) && !ch_ready[sel] &&
                    (TIMEOUT != 0) && (timer == TLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      ch_valid <= 8'd0;
      ch_data  <= '0;
      busy     <= 1'b0;
      timer    <= '0;
      hold     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            hold  <= in_data;
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          // With an empty mask the held word simply waits here.
          if (arb_found) begin
            sel      <= arb_idx;
            ch_data  <= hold;
            ch_valid <= 8'd1 << arb_idx;
            timer    <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer_evt) begin
            ch_valid <= 8'd0;
            ptr      <= sel + 3'd1;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else if (skip_evt) begin
            // Retry the same held word on the next eligible channel.
            ch_valid <= 8'd0;
            ptr      <= sel + 3'd1;
            state    <= S_ARB;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          ch_valid <= 8'd0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
      skip_cnt <= 16'd0;
    end else begin
      if (xfer_evt && (xfer_cnt != 16'hFFFF)) xfer_cnt <= xfer_cnt + 16'd1;
      if (skip_evt && (skip_cnt != 16'hFFFF)) skip_cnt <= skip_cnt + 16'd1;
    end
  end
`endif

endmodule
